ym3014_rx: RTL and testbench
============================

YM3014_RX -- requirements
Module: ym3014_rx

Interface
REQ-001 SYNC_STAGES, 2, number of flip-flops in each input synchronizer (legal 2..3).
REQ-002 iClk  input  1  system clock; all state advances on its rising edge.
REQ-003 iRstN  input  1  reset, asynchronous assert, active-low.
REQ-004 iDacClk  input  1  YM3014 serial bit clock; asynchronous to iClk.
REQ-005 iDacLoad  input  1  YM3014 LOAD; asynchronous to iClk.
REQ-006 iDacSd  input  1  YM3014 serial data; LSB first; asynchronous to iClk.
REQ-007 oSample  output  16  decoded linear sample, signed two's complement.
REQ-008 oValid  output  1  one-cycle pulse; oSample updated this cycle.
REQ-009 oErr  output  1  one-cycle pulse; frame discarded because of a bad bit count.
REQ-010 oPdm  output  1  first-order delta-sigma bitstream of oSample, for a pin RC filter.

Function
REQ-011 The block SHALL pass iDacClk, iDacLoad and iDacSd through SYNC_STAGES-deep synchronizers, then edge-detect against one further register.
REQ-012 On each synchronized iDacClk rising edge, the block SHALL right-shift an 18-bit word register, inserting synchronized iDacSd at bit 17.
- After 18 edges, bit 0 holds the first bit received.
REQ-013 On each synchronized iDacClk rising edge, a 5-bit bit counter SHALL increment, saturating at 31.
REQ-014 Shifting SHALL occur regardless of the iDacLoad level.
- 9 bits normally arrive before LOAD rises and 9 after.
REQ-015 The frame boundary SHALL be the synchronized iDacLoad falling edge.
REQ-016 At the boundary with bit count == 18, the block SHALL copy the word into a decode register; otherwise it SHALL pulse oErr and leave oSample unchanged.
REQ-017 At every boundary, the bit counter SHALL be cleared.
REQ-018 If an iDacClk rising edge and an iDacLoad falling edge are detected in the same cycle, the block SHALL shift first, count that bit, then evaluate.
REQ-019 Word format, w[17:0]:
- w[17:15] = inverted exponent, so e = ~w[17:15].
- w[14] = inverted sign.
- w[13:5] = mantissa bits 8..0.
- w[4:0] = don't care.
REQ-020 Decode SHALL form the 10-bit signed mantissa m = {~w[14], w[13:5]}.
REQ-021 Decode SHALL set oSample = ({m, 6'b0} as signed 16) arithmetically right-shifted by e, for e in 0..7.
- e = 7 is decoded the same way and is not an error.
REQ-022 oSample and oValid SHALL register together, one cycle after the decode register loads.
REQ-023 End-to-end latency: oValid SHALL be high in the cycle following the (SYNC_STAGES+2)-th iClk edge after iDacLoad is first sampled low (4 edges for SYNC_STAGES=2).
REQ-024 The block SHALL NOT emit oValid or oErr other than at a detected LOAD falling edge; at most one of the two pulses per frame.
REQ-025 The PDM SHALL use a 17-bit accumulator updated every iClk: acc <= {1'b0, acc[15:0]} + (oSample ^ 16'h8000).
REQ-026 oPdm SHALL be registered acc[16].
- oSample = 16'h7FFF gives oPdm almost always 1; 16'h8000 gives oPdm = 0.

Reset
REQ-027 While iRstN is low, the block SHALL clear all synchronizers, the edge registers, word register, decode register, bit counter and accumulator.
- oSample = 0, oValid = 0, oErr = 0, oPdm = 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial word.
- The first boundary after release yields oErr if fewer than 18 bits were counted since release; otherwise a normal decode.
REQ-029 A synchronized iDacLoad that is low after reset SHALL NOT be treated as a falling edge.

Verification
REQ-030 Send w = {3'b111, 1'b1, 9'h100, 5'b0} then a LOAD fall -> oValid once, oSample = 16'h4000.
REQ-031 Send w = {3'b001, 1'b1, 9'h100, 5'b0} (e=6) -> oSample = 16'h0100.
REQ-032 Send w = {3'b110, 1'b0, 9'h000, 5'b0} (e=1, m=-512) -> oSample = 16'hC000.
REQ-033 Send only 17 clocks, then 19 clocks, before LOAD falls -> oErr pulses twice, no oValid, oSample holds its prior value.
REQ-034 Assert iRstN low after 9 bits, release, then send one full 18-bit frame -> first boundary: oErr; next boundary: correct oSample.
REQ-035 Hold oSample = 16'h0000 for 2^16 cycles -> oPdm duty cycle = 50% +/- 1 count; measure latency = 4 cycles with SYNC_STAGES=2.

Source files
------------

// File: rtl/ym3014_rx.sv
// YM3014 serial DAC receiver: resynchronises the chip's bit clock, LOAD and data,
// decodes the 3-bit-exponent floating-point word to linear PCM and emits a PDM bitstream.
module ym3014_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iDacClk,
  input  logic        iDacLoad,
  input  logic        iDacSd,
  output logic [15:0] oSample,
  output logic        oValid,
  output logic        oErr,
  output logic        oPdm
);

  logic [SYNC_STAGES-1:0] clk_sync_q, load_sync_q, sd_sync_q;
  logic                   clk_prev_q, load_prev_q;
  logic                   clk_rise, load_fall;
  logic [17:0]            word_q, word_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [17:0]            dec_word_q, dec_word_d;
  logic                   dec_vld_q, dec_vld_d, dec_err_q, dec_err_d;
  logic signed [15:0]     sample_q, sample_d;
  logic                   valid_q, err_q;
  logic [16:0]            acc_q, acc_d;
  logic                   pdm_q;
  logic                   unused_lsbs;

  // Low five bits of the word carry no information.
  assign unused_lsbs = ^dec_word_q[4:0];

  function automatic logic signed [15:0] decode_word(input logic [17:5] w);
    logic [2:0]         e;
    logic signed [15:0] full;
    e    = ~w[17:15];
    full = $signed({~w[14], w[13:5], 6'b0});
    return full >>> e;
  endfunction

  always_comb begin
    clk_rise   = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    load_fall  = ~load_sync_q[SYNC_STAGES-1] & load_prev_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    dec_word_d = dec_word_q;
    dec_vld_d  = 1'b0;
    dec_err_d  = 1'b0;
    // A bit arriving in the boundary cycle belongs to the frame being closed.
    if (clk_rise) begin
      word_d = {sd_sync_q[SYNC_STAGES-1], word_q[17:1]};
      if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
    end
    if (load_fall) begin
      if (cnt_d == 5'd18) begin
        dec_word_d = word_d;
        dec_vld_d  = 1'b1;
      end else begin
        dec_err_d  = 1'b1;
      end
      cnt_d = 5'd0;
    end
    sample_d = dec_vld_q ? decode_word(dec_word_q[17:5]) : sample_q;
    acc_d    = {1'b0, acc_q[15:0]} + {1'b0, sample_q ^ 16'h8000};
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      clk_sync_q  <= '0;
      load_sync_q <= '0;
      sd_sync_q   <= '0;
      clk_prev_q  <= 1'b0;
      load_prev_q <= 1'b0;
      word_q      <= '0;
      cnt_q       <= '0;
      dec_word_q  <= '0;
      dec_vld_q   <= 1'b0;
      dec_err_q   <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      pdm_q       <= 1'b0;
    end else begin
      // synchronizer and edge-detect stage
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], iDacClk};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], iDacLoad};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], iDacSd};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      load_prev_q <= load_sync_q[SYNC_STAGES-1];
      // shift / frame-boundary stage
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      dec_word_q  <= dec_word_d;
      dec_vld_q   <= dec_vld_d;
      dec_err_q   <= dec_err_d;
      // decode output stage
      sample_q    <= sample_d;
      valid_q     <= dec_vld_q;
      err_q       <= dec_err_q;
      // delta-sigma stage
      acc_q       <= acc_d;
      pdm_q       <= acc_q[16];
    end
  end

  assign oSample = sample_q;
  assign oValid  = valid_q;
  assign oErr    = err_q;
  assign oPdm    = pdm_q;

endmodule

// File: tb/tb_ym3014_rx.sv
// Directed bench for ym3014_rx: decode vectors, bad frames, reset mid-frame, latency, PDM duty.
module tb_ym3014_rx;

  logic        iClk = 1'b0;
  logic        iRstN, iDacClk, iDacLoad, iDacSd;
  logic [15:0] oSample;
  logic        oValid, oErr, oPdm;
  int          n_cmp = 0;
  int          n_bad = 0;

  ym3014_rx #(.SYNC_STAGES(2)) dut (
    .iClk(iClk), .iRstN(iRstN), .iDacClk(iDacClk), .iDacLoad(iDacLoad), .iDacSd(iDacSd),
    .oSample(oSample), .oValid(oValid), .oErr(oErr), .oPdm(oPdm)
  );

  always #5 iClk = ~iClk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge iClk);
      #1;
    end
  endtask

  // Bits first..last-1 of w, LSB first; LOAD rises before bit 9.
  task automatic send_bits(input logic [17:0] w, input int first, input int last);
    for (int i = first; i < last; i++) begin
      if (i == 9) iDacLoad = 1'b1;
      iDacSd = (i < 18) ? w[i] : 1'b0;
      step(3);
      iDacClk = 1'b1;
      step(4);
      iDacClk = 1'b0;
      step(1);
    end
  endtask

  task automatic wait_result(output int nv, output int ne, output logic [15:0] s);
    nv = 0; ne = 0; s = oSample;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (oValid) begin nv++; s = oSample; end
      if (oErr) ne++;
    end
  endtask

  task automatic frame(input string name, input logic [17:0] w, input int nbits,
                       input int exp_v, input int exp_e, input logic [15:0] exp_s);
    int nv, ne;
    logic [15:0] s;
    send_bits(w, 0, nbits);
    step(3);
    iDacLoad = 1'b0;
    wait_result(nv, ne, s);
    n_cmp++;
    if (nv !== exp_v) begin n_bad++; $display("FAIL %s valid_count got %0d want %0d", name, nv, exp_v); end
    n_cmp++;
    if (ne !== exp_e) begin n_bad++; $display("FAIL %s err_count got %0d want %0d", name, ne, exp_e); end
    n_cmp++;
    if (s !== exp_s) begin n_bad++; $display("FAIL %s sample got %h want %h", name, s, exp_s); end
  endtask

  task automatic test_reset;
    int seen;
    iRstN = 1'b0; iDacClk = 1'b0; iDacLoad = 1'b0; iDacSd = 1'b0;
    step(5);
    n_cmp++;
    if ({oSample, oValid, oErr, oPdm} !== 19'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h/%b/%b/%b want 0000/0/0/0", oSample, oValid, oErr, oPdm);
    end
    iRstN = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (oValid || oErr) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL low_load_after_reset pulses got %0d want 0", seen); end
  endtask

  task automatic test_decode;
    frame("e0_pos",   {3'b111, 1'b1, 9'h100, 5'b0}, 18, 1, 0, 16'h4000);
    frame("e6_pos",   {3'b001, 1'b1, 9'h100, 5'b0}, 18, 1, 0, 16'h0100);
    frame("e1_neg",   {3'b110, 1'b0, 9'h000, 5'b0}, 18, 1, 0, 16'hC000);
    frame("e7_pos",   {3'b000, 1'b1, 9'h1FF, 5'b0}, 18, 1, 0, 16'h00FF);
    frame("e7_neg",   {3'b000, 1'b0, 9'h1FF, 5'b0}, 18, 1, 0, 16'hFFFF);
  endtask

  task automatic test_latency;
    send_bits({3'b111, 1'b1, 9'h100, 5'b0}, 0, 18);
    step(3);
    iDacLoad = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_cmp++;
      if (oValid !== (k == 4)) begin
        n_bad++; $display("FAIL latency_edge%0d valid got %b want %b", k, oValid, (k == 4));
      end
    end
    n_cmp++;
    if (oSample !== 16'h4000) begin n_bad++; $display("FAIL latency_sample got %h want 4000", oSample); end
    step(8);
  endtask

  task automatic test_bad_count;
    frame("bits17", {3'b001, 1'b1, 9'h100, 5'b0}, 17, 0, 1, 16'h4000);
    frame("bits19", {3'b001, 1'b1, 9'h100, 5'b0}, 19, 0, 1, 16'h4000);
  endtask

  task automatic test_same_cycle;
    logic [17:0] w;
    int nv, ne;
    logic [15:0] s;
    w = {3'b110, 1'b0, 9'h000, 5'b0};
    send_bits(w, 0, 17);
    iDacSd = w[17];
    step(3);
    iDacClk = 1'b1;
    iDacLoad = 1'b0;
    wait_result(nv, ne, s);
    iDacClk = 1'b0;
    step(2);
    n_cmp++;
    if (nv !== 1 || ne !== 0) begin n_bad++; $display("FAIL same_cycle pulses got v%0d e%0d want v1 e0", nv, ne); end
    n_cmp++;
    if (s !== 16'hC000) begin n_bad++; $display("FAIL same_cycle sample got %h want C000", s); end
  endtask

  task automatic test_reset_midframe;
    int nv, ne;
    logic [15:0] s;
    logic [17:0] w;
    w = {3'b111, 1'b1, 9'h1AA, 5'b0};
    send_bits(w, 0, 9);
    iRstN = 1'b0;
    step(3);
    n_cmp++;
    if (oSample !== 16'h0000) begin n_bad++; $display("FAIL midreset_sample got %h want 0000", oSample); end
    iRstN = 1'b1;
    step(2);
    send_bits(w, 9, 18);
    step(3);
    iDacLoad = 1'b0;
    wait_result(nv, ne, s);
    n_cmp++;
    if (nv !== 0 || ne !== 1) begin n_bad++; $display("FAIL midreset_boundary got v%0d e%0d want v0 e1", nv, ne); end
    frame("after_reset", {3'b001, 1'b1, 9'h100, 5'b0}, 18, 1, 0, 16'h0100);
  endtask

  task automatic test_pdm;
    int ones;
    frame("zero", {3'b111, 1'b1, 9'h000, 5'b0}, 18, 1, 0, 16'h0000);
    ones = 0;
    for (int k = 0; k < 65536; k++) begin
      step(1);
      ones += int'(oPdm);
    end
    n_cmp++;
    if (ones < 32767 || ones > 32769) begin n_bad++; $display("FAIL pdm_half ones got %0d want 32768+-1", ones); end
    frame("neg_full", {3'b111, 1'b0, 9'h000, 5'b0}, 18, 1, 0, 16'h8000);
    step(4);
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      step(1);
      ones += int'(oPdm);
    end
    n_cmp++;
    if (ones !== 0) begin n_bad++; $display("FAIL pdm_neg_full ones got %0d want 0", ones); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_latency();
    test_bad_count();
    test_same_cycle();
    test_reset_midframe();
    test_pdm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
